// File: rtl/awmc_drum_plant_pkg.sv
`default_nettype none
// ============================================================================
// Module   : awmc_pkg
// Purpose  : Shared encodings for the washer controller and drum plant:
//            controller stage codes, motor FSM states and fault codes.
// Revision : 1.0 - initial release
// ============================================================================
package awmc_pkg;

    // Controller stage encoding, identical on both sides of the interface.
    typedef enum logic [2:0] {
        FILL  = 3'b000,
        WASH  = 3'b001,
        RINSE = 3'b010,
        SPIN  = 3'b011,
        STOP  = 3'b100,
        IDLE  = 3'b111
    } stage_e;

    // Motor FSM states.
    localparam logic [2:0] M_OFF     = 3'd0;
    localparam logic [2:0] M_AGITATE = 3'd1;
    localparam logic [2:0] M_RAMP    = 3'd2;
    localparam logic [2:0] M_SPIN    = 3'd3;
    localparam logic [2:0] M_BRAKE   = 3'd4;

    // Fault codes; a lower number takes precedence when several fire at once.
    localparam logic [2:0] F_NONE      = 3'd0;
    localparam logic [2:0] F_BOTH_OPEN = 3'd1;
    localparam logic [2:0] F_OVERFLOW  = 3'd2;
    localparam logic [2:0] F_SPIN_WET  = 3'd3;
    localparam logic [2:0] F_DONE_WET  = 3'd4;

endpackage : awmc_pkg
`default_nettype wire

// File: rtl/awmc_drum_plant_if.sv
`default_nettype none
// ============================================================================
// Module   : awmc_drum_plant_if
// Purpose  : Controller <-> drum plant signal bundle.
//            master = controller (drives commands, reads sensors/faults)
//            slave  = drum plant (reads commands, drives sensors/faults)
//   Commands : stage[2:0], input_valve, output_drain, done, clear_fault
//   Sensors  : water_level[LEVEL_W-1:0], level_full, level_empty,
//              motor_state[2:0], door_locked, fault, fault_code[2:0]
// Revision : 1.0 - initial release
// ============================================================================
interface awmc_drum_plant_if #(
    parameter int LEVEL_W = 8
);
    logic [2:0]         stage;
    logic               input_valve;
    logic               output_drain;
    logic               done;
    logic               clear_fault;

    logic [LEVEL_W-1:0] water_level;
    logic               level_full;
    logic               level_empty;
    logic [2:0]         motor_state;
    logic               door_locked;
    logic               fault;
    logic [2:0]         fault_code;

    modport master (
        output stage, input_valve, output_drain, done, clear_fault,
        input  water_level, level_full, level_empty, motor_state,
               door_locked, fault, fault_code
    );

    modport slave (
        input  stage, input_valve, output_drain, done, clear_fault,
        output water_level, level_full, level_empty, motor_state,
               door_locked, fault, fault_code
    );
endinterface : awmc_drum_plant_if
`default_nettype wire

// File: rtl/awmc_drum_plant_level_integrator.sv
`default_nettype none
// ============================================================================
// Module   : awmc_level_integrator
// Purpose  : Saturating water-level register with full/empty compares.
//   clk, reset (async, active-high)
//   input_valve, output_drain : fill / drain commands
//   water_level               : current level
//   level_full, level_empty   : level >= FULL_THRESH / level == 0
// Revision : 1.0 - initial release
// ============================================================================
module awmc_level_integrator #(
    parameter int LEVEL_W     = 8,
    parameter int LEVEL_MAX   = 200,
    parameter int FILL_RATE   = 10,
    parameter int DRAIN_RATE  = 20,
    parameter int FULL_THRESH = 160
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               input_valve,
    input  wire logic               output_drain,
    output logic [LEVEL_W-1:0]      water_level,
    output logic                    level_full,
    output logic                    level_empty
);
    localparam logic [LEVEL_W:0]   c_max   = (LEVEL_W+1)'(LEVEL_MAX);
    localparam logic [LEVEL_W:0]   c_fill  = (LEVEL_W+1)'(FILL_RATE);
    localparam logic [LEVEL_W:0]   c_drain = (LEVEL_W+1)'(DRAIN_RATE);
    localparam logic [LEVEL_W-1:0] c_full  = LEVEL_W'(FULL_THRESH);

    logic [LEVEL_W-1:0] r_level;
    logic [LEVEL_W:0]   w_sum;
    logic [LEVEL_W:0]   w_diff;
    logic [LEVEL_W-1:0] w_filled;
    logic [LEVEL_W-1:0] w_drained;

    // One extra bit: the carry catches overshoot, the MSB of the
    // difference flags a borrow (level below DRAIN_RATE).
    assign w_sum     = {1'b0, r_level} + c_fill;
    assign w_diff    = {1'b0, r_level} - c_drain;
    assign w_filled  = (w_sum > c_max) ? c_max[LEVEL_W-1:0] : w_sum[LEVEL_W-1:0];
    assign w_drained = w_diff[LEVEL_W] ? '0 : w_diff[LEVEL_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level <= '0;
        end else if (input_valve && !output_drain) begin
            r_level <= w_filled;
        end else if (!input_valve && output_drain) begin
            r_level <= w_drained;
        end
    end

    assign water_level = r_level;
    assign level_full  = (r_level >= c_full);
    assign level_empty = (r_level == '0);

endmodule : awmc_level_integrator
`default_nettype wire

// File: rtl/awmc_drum_plant.sv
`default_nettype none
// ============================================================================
// Module   : awmc_drum_plant
// Purpose  : Drum-side responder for the washer controller: water level,
//            motor FSM (agitate / ramp / spin / brake), door interlock and
//            sticky protocol-fault latch. Faults are observe-only.
//   clk, reset (async, active-high)
//   bus (slave modport): commands in, sensors and fault status out
// Revision : 1.0 - initial release
// ============================================================================
module awmc_drum_plant
    import awmc_pkg::*;
#(
    parameter int LEVEL_W        = 8,
    parameter int LEVEL_MAX      = 200,
    parameter int FILL_RATE      = 10,
    parameter int DRAIN_RATE     = 20,
    parameter int FULL_THRESH    = 160,
    parameter int MIN_WASH_LEVEL = 100,
    parameter int SPIN_MAX_LEVEL = 20,
    parameter int RAMP_CYCLES    = 4,
    parameter int BRAKE_CYCLES   = 3,
    parameter int SPIN_WET_LIMIT = 3
) (
    input  wire logic        clk,
    input  wire logic        reset,
    awmc_drum_plant_if.slave bus
);
    localparam int RAMP_W  = $clog2(RAMP_CYCLES + 1);
    localparam int BRAKE_W = $clog2(BRAKE_CYCLES + 1);
    localparam int WET_W   = $clog2(SPIN_WET_LIMIT + 1);

    localparam logic [RAMP_W-1:0]  c_ramp_last  = RAMP_W'(RAMP_CYCLES - 1);
    localparam logic [BRAKE_W-1:0] c_brake_last = BRAKE_W'(BRAKE_CYCLES - 1);
    localparam logic [WET_W-1:0]   c_wet_last   = WET_W'(SPIN_WET_LIMIT - 1);
    localparam logic [LEVEL_W-1:0] c_level_max  = LEVEL_W'(LEVEL_MAX);
    localparam logic [LEVEL_W-1:0] c_wash_min   = LEVEL_W'(MIN_WASH_LEVEL);
    localparam logic [LEVEL_W-1:0] c_spin_max   = LEVEL_W'(SPIN_MAX_LEVEL);

    logic [LEVEL_W-1:0] w_level;
    logic               w_empty;
    logic               w_full;

    awmc_level_integrator #(
        .LEVEL_W     (LEVEL_W),
        .LEVEL_MAX   (LEVEL_MAX),
        .FILL_RATE   (FILL_RATE),
        .DRAIN_RATE  (DRAIN_RATE),
        .FULL_THRESH (FULL_THRESH)
    ) u_level (
        .clk          (clk),
        .reset        (reset),
        .input_valve  (bus.input_valve),
        .output_drain (bus.output_drain),
        .water_level  (w_level),
        .level_full   (w_full),
        .level_empty  (w_empty)
    );

    // ---------------------------------------------------------------- motor
    logic [2:0]         r_motor;
    logic [RAMP_W-1:0]  r_ramp_cnt;
    logic [BRAKE_W-1:0] r_brake_cnt;
    logic               w_wash_stage;
    logic               w_wash_ok;
    logic               w_spin_ok;
    logic               w_is_spin;

    assign w_is_spin    = (bus.stage == SPIN);
    assign w_wash_stage = (bus.stage == WASH) || (bus.stage == RINSE);
    assign w_wash_ok    = w_wash_stage && (w_level >= c_wash_min);
    assign w_spin_ok    = w_is_spin && (w_level <= c_spin_max);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_motor     <= M_OFF;
            r_ramp_cnt  <= '0;
            r_brake_cnt <= '0;
        end else begin
            case (r_motor)
                M_OFF: begin
                    if (w_wash_ok) begin
                        r_motor <= M_AGITATE;
                    end else if (w_spin_ok) begin
                        r_motor    <= M_RAMP;
                        r_ramp_cnt <= '0;
                    end
                end
                M_AGITATE: begin
                    if (w_spin_ok) begin
                        r_motor    <= M_RAMP;
                        r_ramp_cnt <= '0;
                    end else if (!w_wash_ok) begin
                        r_motor <= M_OFF;
                    end
                end
                M_RAMP: begin
                    if (!w_is_spin) begin
                        r_motor     <= M_BRAKE;
                        r_brake_cnt <= '0;
                    end else if (r_ramp_cnt == c_ramp_last) begin
                        r_motor <= M_SPIN;
                    end else begin
                        r_ramp_cnt <= r_ramp_cnt + 1'b1;
                    end
                end
                M_SPIN: begin
                    if (!w_is_spin) begin
                        r_motor     <= M_BRAKE;
                        r_brake_cnt <= '0;
                    end
                end
                M_BRAKE: begin
                    // Brake always runs to completion regardless of stage.
                    if (r_brake_cnt == c_brake_last) begin
                        r_motor <= M_OFF;
                    end else begin
                        r_brake_cnt <= r_brake_cnt + 1'b1;
                    end
                end
                default: r_motor <= M_OFF;
            endcase
        end
    end

    // --------------------------------------------------------------- faults
    logic [WET_W-1:0] r_wet_cnt;
    logic             w_wet_cond;
    logic             w_wet_det;
    logic [2:0]       w_code;
    logic             r_fault;
    logic [2:0]       r_fault_code;

    assign w_wet_cond = w_is_spin && (w_level > c_spin_max);
    // Counter saturates so a persisting wet-spin keeps detecting (re-latch
    // after clear_fault needs no new run-up).
    assign w_wet_det  = w_wet_cond && (r_wet_cnt == c_wet_last);

    always_comb begin
        w_code = F_NONE;
        if (bus.done && !w_empty)                               w_code = F_DONE_WET;
        if (w_wet_det)                                          w_code = F_SPIN_WET;
        if (bus.input_valve && !bus.output_drain &&
            (w_level == c_level_max))                           w_code = F_OVERFLOW;
        if (bus.input_valve && bus.output_drain)                w_code = F_BOTH_OPEN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wet_cnt    <= '0;
            r_fault      <= 1'b0;
            r_fault_code <= F_NONE;
        end else begin
            if (!w_wet_cond) begin
                r_wet_cnt <= '0;
            end else if (r_wet_cnt != c_wet_last) begin
                r_wet_cnt <= r_wet_cnt + 1'b1;
            end

            if (bus.clear_fault) begin
                r_fault      <= 1'b0;
                r_fault_code <= F_NONE;
            end else if (!r_fault && (w_code != F_NONE)) begin
                r_fault      <= 1'b1;
                r_fault_code <= w_code;
            end
        end
    end

    // -------------------------------------------------------------- outputs
    assign bus.water_level = w_level;
    assign bus.level_full  = w_full;
    assign bus.level_empty = w_empty;
    assign bus.motor_state = r_motor;
    assign bus.door_locked = (r_motor != M_OFF) || !w_empty;
    assign bus.fault       = r_fault;
    assign bus.fault_code  = r_fault_code;

endmodule : awmc_drum_plant
`default_nettype wire

// File: tb/tb_awmc_drum_plant.sv
`default_nettype none
// ============================================================================
// Module   : tb_awmc_drum_plant
// Purpose  : Directed self-checking bench for awmc_drum_plant with
//            hand-computed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_awmc_drum_plant;
    import awmc_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    awmc_drum_plant_if #(.LEVEL_W(8)) bus ();

    awmc_drum_plant u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset            = 1'b1;
        bus.stage        = STOP;
        bus.input_valve  = 1'b0;
        bus.output_drain = 1'b0;
        bus.done         = 1'b0;
        bus.clear_fault  = 1'b0;
        #12;
        check_val("rst_level", int'(bus.water_level), 0);
        check_val("rst_empty", int'(bus.level_empty), 1);
        check_val("rst_full",  int'(bus.level_full), 0);
        check_val("rst_motor", int'(bus.motor_state), 0);
        check_val("rst_door",  int'(bus.door_locked), 0);
        check_val("rst_fault", int'(bus.fault), 0);
        check_val("rst_code",  int'(bus.fault_code), 0);
        reset = 1'b0;

        // Fill 17 cycles
        bus.stage = FILL;
        bus.input_valve = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step(1);
            check_val("fill_level", int'(bus.water_level), 10 * k);
            check_val("fill_full", int'(bus.level_full), (k >= 16) ? 1 : 0);
        end
        check_val("fill_empty", int'(bus.level_empty), 0);
        check_val("fill_nofault", int'(bus.fault), 0);

        // Up to ceiling, then one overflowing cycle
        step(3);
        check_val("ceil_level", int'(bus.water_level), 200);
        check_val("ceil_nofault", int'(bus.fault), 0);
        step(1);
        check_val("ovf_level", int'(bus.water_level), 200);
        check_val("ovf_fault", int'(bus.fault), 1);
        check_val("ovf_code", int'(bus.fault_code), 2);

        // Drain 11 cycles, no wrap
        bus.input_valve = 1'b0;
        bus.output_drain = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step(1);
            check_val("drain_level", int'(bus.water_level), (200 - 20 * k > 0) ? 200 - 20 * k : 0);
        end
        check_val("drain_empty", int'(bus.level_empty), 1);
        check_val("drain_code_held", int'(bus.fault_code), 2);
        bus.output_drain = 1'b0;
        bus.clear_fault = 1'b1;
        step(1);
        bus.clear_fault = 1'b0;
        check_val("clr_fault", int'(bus.fault), 0);
        check_val("clr_code", int'(bus.fault_code), 0);

        // Wash agitation and pause
        bus.input_valve = 1'b1;
        step(12);
        bus.input_valve = 1'b0;
        check_val("wash_level", int'(bus.water_level), 120);
        bus.stage = WASH;
        step(1);
        check_val("wash_motor", int'(bus.motor_state), 1);
        check_val("wash_door", int'(bus.door_locked), 1);
        bus.stage = IDLE;
        step(1);
        check_val("pause_motor", int'(bus.motor_state), 0);
        check_val("pause_door", int'(bus.door_locked), 1);
        check_val("pause_level", int'(bus.water_level), 120);

        // Spin ramp and brake
        bus.stage = STOP;
        bus.output_drain = 1'b1;
        step(6);
        bus.output_drain = 1'b0;
        check_val("spin_pre_level", int'(bus.water_level), 0);
        bus.stage = SPIN;
        step(1);
        check_val("ramp_1", int'(bus.motor_state), 2);
        step(3);
        check_val("ramp_4", int'(bus.motor_state), 2);
        step(1);
        check_val("spin_in", int'(bus.motor_state), 3);
        step(1);
        check_val("spin_hold", int'(bus.motor_state), 3);
        bus.stage = STOP;
        step(1);
        check_val("brake_1", int'(bus.motor_state), 4);
        bus.stage = SPIN;
        step(1);
        check_val("brake_2", int'(bus.motor_state), 4);
        step(1);
        check_val("brake_3", int'(bus.motor_state), 4);
        step(1);
        check_val("brake_off", int'(bus.motor_state), 0);
        check_val("brake_door", int'(bus.door_locked), 0);
        bus.stage = STOP;

        // Spin wet
        bus.stage = FILL;
        bus.input_valve = 1'b1;
        step(10);
        bus.input_valve = 1'b0;
        check_val("wet_level", int'(bus.water_level), 100);
        bus.stage = SPIN;
        step(1);
        check_val("wet_c1_fault", int'(bus.fault), 0);
        check_val("wet_c1_motor", int'(bus.motor_state), 0);
        step(1);
        check_val("wet_c2_fault", int'(bus.fault), 0);
        step(1);
        check_val("wet_c3_fault", int'(bus.fault), 1);
        check_val("wet_c3_code", int'(bus.fault_code), 3);
        check_val("wet_c3_motor", int'(bus.motor_state), 0);
        bus.clear_fault = 1'b1;
        step(1);
        bus.clear_fault = 1'b0;
        check_val("wet_clr_fault", int'(bus.fault), 0);
        step(1);
        check_val("wet_relatch", int'(bus.fault), 1);
        check_val("wet_relatch_code", int'(bus.fault_code), 3);

        // Simultaneous faults at level 50
        bus.stage = STOP;
        bus.output_drain = 1'b1;
        step(5);
        bus.output_drain = 1'b0;
        bus.input_valve = 1'b1;
        step(5);
        bus.input_valve = 1'b0;
        bus.clear_fault = 1'b1;
        step(1);
        bus.clear_fault = 1'b0;
        check_val("sim_pre_level", int'(bus.water_level), 50);
        check_val("sim_pre_fault", int'(bus.fault), 0);
        bus.input_valve = 1'b1;
        bus.output_drain = 1'b1;
        bus.done = 1'b1;
        step(1);
        bus.input_valve = 1'b0;
        bus.output_drain = 1'b0;
        bus.done = 1'b0;
        check_val("sim_fault", int'(bus.fault), 1);
        check_val("sim_code", int'(bus.fault_code), 1);
        check_val("sim_level", int'(bus.water_level), 50);

        // Async reset mid-SPIN
        bus.output_drain = 1'b1;
        step(3);
        bus.output_drain = 1'b0;
        bus.stage = SPIN;
        step(5);
        bus.input_valve = 1'b1;
        step(1);
        bus.input_valve = 1'b0;
        check_val("pre_rst_motor", int'(bus.motor_state), 3);
        check_val("pre_rst_level", int'(bus.water_level), 10);
        #2;
        reset = 1'b1;
        #1;
        check_val("arst_level", int'(bus.water_level), 0);
        check_val("arst_motor", int'(bus.motor_state), 0);
        check_val("arst_fault", int'(bus.fault), 0);
        check_val("arst_code", int'(bus.fault_code), 0);
        check_val("arst_empty", int'(bus.level_empty), 1);
        check_val("arst_door", int'(bus.door_locked), 0);
        step(1);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_awmc_drum_plant
`default_nettype wire

// File: doc/awmc_drum_plant.md
Name: awmc_drum_plant

Overview:
- Responder end of the washer controller interface.
- Consumes the controller's commands (stage, input_valve, output_drain, done) and models the drum side: water-level integrator, motor state machine with spin ramp and brake, door interlock.
- Returns sensor flags to the controller.
- Latches protocol faults for the top level and the bench monitor.
- Sits directly beside the controller at top level; also serves as the closed-loop plant in system simulation.

Parameters:
- LEVEL_W, 8, width of water_level.
- LEVEL_MAX, 200, saturation ceiling of the level.
- FILL_RATE, 10, level increment per fill cycle.
- DRAIN_RATE, 20, level decrement per drain cycle.
- FULL_THRESH, 160, level at or above which level_full=1.
- MIN_WASH_LEVEL, 100, minimum level for agitation.
- SPIN_MAX_LEVEL, 20, maximum level allowed for spin ramp.
- RAMP_CYCLES, 4, cycles in RAMP before SPIN.
- BRAKE_CYCLES, 3, cycles in BRAKE before OFF.
- SPIN_WET_LIMIT, 3, consecutive too-wet SPIN-stage cycles before fault.

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous active-high reset.
- stage, input, 3, controller stage (shared encoding).
- input_valve, input, 1, fill valve command.
- output_drain, input, 1, drain pump command.
- done, input, 1, controller cycle-complete flag.
- clear_fault, input, 1, synchronous fault clear.
- water_level, output, LEVEL_W, current modelled level.
- level_full, output, 1, water_level >= FULL_THRESH.
- level_empty, output, 1, water_level == 0.
- motor_state, output, 3, current motor FSM state.
- door_locked, output, 1, (motor_state != M_OFF) || !level_empty.
- fault, output, 1, sticky fault present.
- fault_code, output, 3, code of first latched fault.

Behaviour:
- Interface and reset:
  - Clock clk; reset is asynchronous, active-high.
  - Reset values: water_level=0, motor_state=M_OFF, fault=0, fault_code=F_NONE, internal counters=0.
  - level_full, level_empty and door_locked are combinational from registers, so after reset they are 0, 1 and 0.
- Level update, one register update per cycle:
  - valve=1, drain=0: level = min(level+FILL_RATE, LEVEL_MAX).
  - valve=0, drain=1: level = max(level-DRAIN_RATE, 0).
  - Both 1: level holds.
  - Both 0: level holds.
  - Arithmetic is done in LEVEL_W+1 bits and saturates; no wrap-around.
- Motor FSM, registered, states:
  - M_OFF: goes to M_AGITATE when stage is WASH or RINSE and level >= MIN_WASH_LEVEL. Goes to M_RAMP when stage==SPIN and level <= SPIN_MAX_LEVEL; the ramp counter loads 0 on entry.
  - M_AGITATE: goes to M_OFF immediately if stage is not WASH/RINSE, or if level < MIN_WASH_LEVEL. Goes to M_RAMP directly if stage==SPIN and level <= SPIN_MAX_LEVEL.
  - M_RAMP: the counter increments each cycle and the state goes to M_SPIN after RAMP_CYCLES cycles in RAMP. If stage != SPIN, it goes to M_BRAKE.
  - M_SPIN: holds while stage==SPIN; otherwise goes to M_BRAKE.
  - M_BRAKE: counts BRAKE_CYCLES, then goes to M_OFF. It cannot be aborted, even if stage returns to SPIN; re-entry to RAMP happens only via M_OFF.
- Pause handling: stage==IDLE (controller pause) follows the rules above. AGITATE goes to OFF at once; RAMP/SPIN go to BRAKE.
- Fault detection, evaluated each cycle on the current inputs and registers:
  - F_BOTH_OPEN=1: valve && drain.
  - F_OVERFLOW=2: valve && !drain && level==LEVEL_MAX.
  - F_SPIN_WET=3: stage==SPIN && level > SPIN_MAX_LEVEL for SPIN_WET_LIMIT consecutive cycles. The counter resets on any non-qualifying cycle.
  - F_DONE_WET=4: done && level != 0.
- Fault latching:
  - On the first detection with fault=0, fault<=1 and fault_code<=the lowest-numbered active code.
  - Later faults are ignored until clear_fault.
  - clear_fault has priority over a new detection in the same cycle: the fault clears, and a still-present condition re-latches on the next cycle.
- Faults do not alter level or motor behaviour (observe-only).
- Reset mid-operation forces all state to reset values in the same instant; there is no brake sequence on reset.

Decomposition:
- Package awmc_pkg:
  - stage encodings: IDLE=3'b111, FILL=000, WASH=001, RINSE=010, SPIN=011, STOP=100.
  - motor states: M_OFF=0, M_AGITATE=1, M_RAMP=2, M_SPIN=3, M_BRAKE=4.
  - fault codes: F_NONE=0 .. F_DONE_WET=4.
- The controller adopts the same package.
- One sub-module: awmc_level_integrator, the saturating level register plus the level_full/level_empty compare.
- The motor FSM and fault logic stay in the top of this block.

Test Plan:
- Fill: reset, then valve=1, drain=0 for 17 cycles.
  - Required: level 10,20,…,160; level_full=1 after cycle 16; level 170 after cycle 17; level_empty=0.
- Overflow and drain saturation:
  - Continue fill to 200, then one more valve cycle: level stays 200; fault=1, code=2.
  - Next, drain for 11 cycles: level reaches 0 with no underflow wrap.
- Wash agitation and pause:
  - level=120, stage=WASH: motor_state=M_AGITATE next cycle.
  - stage=IDLE: M_OFF next cycle; door_locked stays 1 while level=120.
- Spin ramp and brake:
  - level=0, stage=SPIN: RAMP, then SPIN after 4 cycles.
  - stage=STOP: BRAKE for 3 cycles, then M_OFF; door_locked=0.
  - stage returned to SPIN during BRAKE: brake still completes.
- Spin wet:
  - level=100, stage=SPIN: motor stays M_OFF; fault code=3 after cycle 3.
  - clear_fault with the condition still present: fault re-latches the following cycle.
- Simultaneous faults:
  - valve=1, drain=1, done=1 with level=50: code=1 (lowest wins); level unchanged at 50.
  - Async reset asserted mid-SPIN: all outputs at reset values immediately.
